branch_resolve_ctrl: RTL and testbench

//  Sequences branch resolution for the MIPS pipeline: accepts one branch op from decode (valid/ready),

---
 rtl/branch_resolve_ctrl.sv | 160 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: accepts a decoded branch, waits for forwarded operands,
// evaluates the condition, pulses a PC redirect and holds flush; keeps saturating stats.
module branch_resolve_ctrl #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [5:0]        br_op,
  input  logic [DATA_W-1:0] br_pc,
  input  logic [DATA_W-1:0] br_offset,
  input  logic              ops_ready,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              kill,
  input  logic              stats_clr,
  output logic              stall,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_OPS = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
  localparam logic [1:0] S_FLUSH    = 2'd3;

  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLEZ = 6'b011000;
  localparam logic [5:0] OP_BGTZ = 6'b011001;
  localparam logic [5:0] OP_BGEZ = 6'b011010;

  localparam int unsigned FC_W    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned FC_LOAD = (FLUSH_CYCLES >= 2) ? (FLUSH_CYCLES - 2) : 0;

  logic [1:0]        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] off_q, off_d;
  logic [DATA_W-1:0] rpc_q, rpc_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  brc_q, brc_d;
  logic [CNT_W-1:0]  tkc_q, tkc_d;

  logic              taken;
  logic              br_inc;
  logic              tk_inc;
  logic [DATA_W-1:0] target;

  always_comb begin
    taken = 1'b0;
    case (op_q)
      OP_BEQ:  taken = (rs_data == rt_data);
      OP_BNE:  taken = (rs_data != rt_data);
      OP_BLEZ: taken = ($signed(rs_data) <= 0);
      OP_BGTZ: taken = ($signed(rs_data) > 0);
      OP_BGEZ: taken = ($signed(rs_data) >= 0);
      default: taken = 1'b0;
    endcase
  end

  assign target = pc_q + DATA_W'(4) + (off_q << 2);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    off_d   = off_q;
    rpc_d   = rpc_q;
    fcnt_d  = fcnt_q;
    br_inc  = 1'b0;
    tk_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          op_d    = br_op;
          pc_d    = br_pc;
          off_d   = br_offset;
          state_d = S_WAIT_OPS;
        end
      end
      S_WAIT_OPS: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (ops_ready) begin
          br_inc = 1'b1;
          if (taken) begin
            tk_inc  = 1'b1;
            rpc_d   = target;
            state_d = S_REDIRECT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_REDIRECT: begin
        if (FLUSH_CYCLES <= 1) begin
          state_d = S_IDLE;
        end else begin
          fcnt_d  = FC_W'(FC_LOAD);
          state_d = S_FLUSH;
        end
      end
      default: begin
        if (fcnt_q == '0) state_d = S_IDLE;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
    endcase
  end

  // Clear takes precedence over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    brc_d = brc_q;
    tkc_d = tkc_q;
    if (stats_clr) begin
      brc_d = '0;
      tkc_d = '0;
    end else begin
      if (br_inc && (brc_q != '1)) brc_d = brc_q + CNT_W'(1);
      if (tk_inc && (tkc_q != '1)) tkc_d = tkc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      pc_q    <= '0;
      off_q   <= '0;
      rpc_q   <= '0;
      fcnt_q  <= '0;
      brc_q   <= '0;
      tkc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      off_q   <= off_d;
      rpc_q   <= rpc_d;
      fcnt_q  <= fcnt_d;
      brc_q   <= brc_d;
      tkc_q   <= tkc_d;
    end
  end

  assign br_ready       = (state_q == S_IDLE);
  assign stall          = (state_q == S_WAIT_OPS);
  assign redirect_valid = (state_q == S_REDIRECT);
  assign flush          = (state_q == S_REDIRECT) || (state_q == S_FLUSH);
  assign redirect_pc    = rpc_q;
  assign br_count       = brc_q;
  assign taken_count    = tkc_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl (main instance FLUSH_CYCLES=2,
// narrow counters to reach saturation; second instance FLUSH_CYCLES=1).
module tb_branch_resolve_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [5:0] BEQ  = 6'b010110;
  localparam logic [5:0] BNE  = 6'b010111;
  localparam logic [5:0] BLEZ = 6'b011000;
  localparam logic [5:0] BGTZ = 6'b011001;
  localparam logic [5:0] BGEZ = 6'b011010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          br_valid = 1'b0;
  logic [5:0]    br_op = '0;
  logic [DW-1:0] br_pc = '0;
  logic [DW-1:0] br_offset = '0;
  logic          ops_ready = 1'b0;
  logic [DW-1:0] rs_data = '0;
  logic [DW-1:0] rt_data = '0;
  logic          kill = 1'b0;
  logic          stats_clr = 1'b0;

  logic          br_ready, stall, redirect_valid, flush;
  logic [DW-1:0] redirect_pc;
  logic [CW-1:0] br_count, taken_count;

  logic          br_ready1, stall1, redirect_valid1, flush1;
  logic [DW-1:0] redirect_pc1;
  logic [CW-1:0] br_count1, taken_count1;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] exp_br = '0;
  logic [CW-1:0] exp_tk = '0;

  branch_resolve_ctrl #(.DATA_W(DW), .FLUSH_CYCLES(2), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_op(br_op), .br_pc(br_pc), .br_offset(br_offset), .ops_ready(ops_ready),
    .rs_data(rs_data), .rt_data(rt_data), .kill(kill), .stats_clr(stats_clr),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .br_count(br_count), .taken_count(taken_count)
  );

  branch_resolve_ctrl #(.DATA_W(DW), .FLUSH_CYCLES(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready1),
    .br_op(br_op), .br_pc(br_pc), .br_offset(br_offset), .ops_ready(ops_ready),
    .rs_data(rs_data), .rt_data(rt_data), .kill(kill), .stats_clr(stats_clr),
    .stall(stall1), .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
    .flush(flush1), .br_count(br_count1), .taken_count(taken_count1)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a branch for one edge once the controller is idle; afterwards we sit in cycle 1.
  task automatic issue(input logic [5:0] op, input logic [DW-1:0] pc, input logic [DW-1:0] off);
    int n = 0;
    while (!br_ready && n < 20) begin tick(); n++; end
    if (!br_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout br_ready=%0b want 1", br_ready);
    end
    br_valid = 1'b1; br_op = op; br_pc = pc; br_offset = off;
    tick();
    br_valid = 1'b0;
  endtask

  // Offer operands for one edge; afterwards we sit in cycle 2.
  task automatic resolve(input logic [DW-1:0] rs, input logic [DW-1:0] rt);
    ops_ready = 1'b1; rs_data = rs; rt_data = rt;
    tick();
    ops_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!br_ready && n < 20) begin tick(); n++; end
    if (!br_ready) begin
      total++; bad++;
      $display("FAIL drain_timeout br_ready=%0b want 1", br_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (br_ready !== 1'b1 || stall !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got rdy=%0b stall=%0b rv=%0b fl=%0b want 1 0 0 0",
                      br_ready, stall, redirect_valid, flush);
    end
    total++; if (redirect_pc !== '0 || br_count !== '0 || taken_count !== '0) begin
      bad++; $display("FAIL reset_data got pc=%h br=%0d tk=%0d want 0 0 0", redirect_pc, br_count, taken_count);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_beq_taken();
    issue(BEQ, 32'h100, 32'h4);
    total++; if (stall !== 1'b1 || br_ready !== 1'b0) begin
      bad++; $display("FAIL beq_wait got stall=%0b rdy=%0b want 1 0", stall, br_ready);
    end
    resolve(32'd7, 32'd7);
    exp_br = sat_inc(exp_br); exp_tk = sat_inc(exp_tk);
    total++; if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h114) begin
      bad++; $display("FAIL beq_redirect got rv=%0b fl=%0b pc=%h want 1 1 00000114", redirect_valid, flush, redirect_pc);
    end
    total++; if (br_count !== exp_br || taken_count !== exp_tk) begin
      bad++; $display("FAIL beq_counts got br=%0d tk=%0d want %0d %0d", br_count, taken_count, exp_br, exp_tk);
    end
    total++; if (redirect_valid1 !== 1'b1 || flush1 !== 1'b1 || redirect_pc1 !== 32'h114) begin
      bad++; $display("FAIL fc1_redirect got rv=%0b fl=%0b pc=%h want 1 1 00000114", redirect_valid1, flush1, redirect_pc1);
    end
    tick();
    total++; if (redirect_valid !== 1'b0 || flush !== 1'b1 || br_ready !== 1'b0 || redirect_pc !== 32'h114) begin
      bad++; $display("FAIL beq_flush2 got rv=%0b fl=%0b rdy=%0b pc=%h want 0 1 0 00000114",
                      redirect_valid, flush, br_ready, redirect_pc);
    end
    total++; if (flush1 !== 1'b0 || br_ready1 !== 1'b1) begin
      bad++; $display("FAIL fc1_done got fl=%0b rdy=%0b want 0 1", flush1, br_ready1);
    end
    tick();
    total++; if (flush !== 1'b0 || br_ready !== 1'b1) begin
      bad++; $display("FAIL beq_done got fl=%0b rdy=%0b want 0 1", flush, br_ready);
    end
  endtask

  task automatic test_bne_not_taken();
    issue(BNE, 32'h200, 32'h8);
    resolve(32'd5, 32'd5);
    exp_br = sat_inc(exp_br);
    total++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || br_ready !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL bne_idle got rv=%0b fl=%0b rdy=%0b stall=%0b want 0 0 1 0",
                      redirect_valid, flush, br_ready, stall);
    end
    total++; if (br_count !== exp_br || taken_count !== exp_tk || redirect_pc !== 32'h114) begin
      bad++; $display("FAIL bne_counts got br=%0d tk=%0d pc=%h want %0d %0d 00000114",
                      br_count, taken_count, redirect_pc, exp_br, exp_tk);
    end
  endtask

  task automatic test_conditions();
    logic [5:0]    ops [5] = '{BLEZ, BGTZ, BGEZ, BGEZ, 6'b000000};
    logic [DW-1:0] rss [5] = '{32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic          exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], 32'h1000, 32'h10);
      resolve(rss[i], 32'h0);
      exp_br = sat_inc(exp_br);
      if (exp[i]) exp_tk = sat_inc(exp_tk);
      total++; if (redirect_valid !== exp[i] || br_ready !== !exp[i]) begin
        bad++; $display("FAIL cond_%0d got rv=%0b rdy=%0b want %0b %0b", i, redirect_valid, br_ready, exp[i], !exp[i]);
      end
      total++; if (br_count !== exp_br || taken_count !== exp_tk) begin
        bad++; $display("FAIL cond_cnt_%0d got br=%0d tk=%0d want %0d %0d", i, br_count, taken_count, exp_br, exp_tk);
      end
      if (exp[i]) begin
        total++; if (redirect_pc !== 32'h1044) begin
          bad++; $display("FAIL cond_pc_%0d got %h want 00001044", i, redirect_pc);
        end
      end
      drain();
    end
  endtask

  task automatic test_stall();
    int n = 0;
    issue(BNE, 32'h300, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (stall) n++;
      tick();
    end
    ops_ready = 1'b1; rs_data = 32'd1; rt_data = 32'd1;
    if (stall) n++;
    tick();
    ops_ready = 1'b0;
    exp_br = sat_inc(exp_br);
    for (int i = 0; i < 3; i++) begin
      if (stall) n++;
      tick();
    end
    total++; if (n != 6) begin
      bad++; $display("FAIL stall_cycles got %0d want 6", n);
    end
    // kill wins over ops_ready in the same cycle
    issue(BEQ, 32'h400, 32'h2);
    kill = 1'b1; ops_ready = 1'b1; rs_data = 32'd9; rt_data = 32'd9;
    tick();
    kill = 1'b0; ops_ready = 1'b0;
    total++; if (redirect_valid !== 1'b0 || br_ready !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL kill_idle got rv=%0b rdy=%0b stall=%0b want 0 1 0", redirect_valid, br_ready, stall);
    end
    total++; if (br_count !== exp_br || taken_count !== exp_tk) begin
      bad++; $display("FAIL kill_counts got br=%0d tk=%0d want %0d %0d", br_count, taken_count, exp_br, exp_tk);
    end
  endtask

  task automatic test_wrap();
    issue(BEQ, 32'hFFFFFFF8, 32'h1);
    resolve(32'd3, 32'd3);
    exp_br = sat_inc(exp_br); exp_tk = sat_inc(exp_tk);
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
      bad++; $display("FAIL wrap_pc got rv=%0b pc=%h want 1 00000000", redirect_valid, redirect_pc);
    end
    drain();
    issue(BEQ, 32'h100, 32'hFFFFFFFE);
    resolve(32'd3, 32'd3);
    exp_br = sat_inc(exp_br); exp_tk = sat_inc(exp_tk);
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hFC) begin
      bad++; $display("FAIL neg_off_pc got rv=%0b pc=%h want 1 000000fc", redirect_valid, redirect_pc);
    end
    drain();
  endtask

  task automatic test_reset_in_flush();
    issue(BEQ, 32'h500, 32'h3);
    resolve(32'd1, 32'd1);
    tick();
    total++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      bad++; $display("FAIL pre_reset_flush got fl=%0b rv=%0b want 1 0", flush, redirect_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (flush !== 1'b0 || br_ready !== 1'b1 || redirect_pc !== '0 || br_count !== '0 || taken_count !== '0) begin
      bad++; $display("FAIL async_reset got fl=%0b rdy=%0b pc=%h br=%0d tk=%0d want 0 1 0 0 0",
                      flush, br_ready, redirect_pc, br_count, taken_count);
    end
    exp_br = '0; exp_tk = '0;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      issue(BEQ, 32'h600, 32'h0);
      resolve(32'd2, 32'd2);
      exp_br = sat_inc(exp_br); exp_tk = sat_inc(exp_tk);
      drain();
    end
    total++; if (br_count !== 4'hF || taken_count !== 4'hF || exp_br !== 4'hF) begin
      bad++; $display("FAIL saturate got br=%0d tk=%0d want 15 15", br_count, taken_count);
    end
    issue(BEQ, 32'h700, 32'h0);
    stats_clr = 1'b1;
    resolve(32'd2, 32'd2);
    stats_clr = 1'b0;
    exp_br = '0; exp_tk = '0;
    total++; if (br_count !== exp_br || taken_count !== exp_tk || redirect_valid !== 1'b1) begin
      bad++; $display("FAIL clr_wins got br=%0d tk=%0d rv=%0b want 0 0 1", br_count, taken_count, redirect_valid);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_conditions();
    test_stall();
    test_wrap();
    test_reset_in_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached want finish");
    $fatal(1);
  end
endmodule
